axi_lite_cmd_master: RTL and testbench

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_lite_cmd_master.sv | 141 ++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: one-outstanding AXI4-Lite master driven by a command/response port, with per-handshake timeout
module axi_lite_cmd_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]                   cmd_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [31:0]                   rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          rsp_timeout,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic [31:0]                   m_axi_wdata,
   output logic [3:0]                    m_axi_wstrb,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [1:0]                    m_axi_bresp,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [31:0]                   m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp
);
   typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic aw_done, w_done, expired;
   assign m_axi_wstrb = 4'hf;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   // a channel counts as done once its valid has dropped or it is handshaking now
   always_comb begin
      aw_done = !m_axi_awvalid || m_axi_awready;
      w_done = !m_axi_wvalid || m_axi_wready;
      expired = (cnt == LAST) && (state == WR_ADDR_DATA ? !(aw_done && w_done) :
                                  state == WR_RESP      ? !m_axi_bvalid :
                                  state == RD_ADDR      ? !m_axi_arready :
                                  state == RD_DATA      ? !m_axi_rvalid : 1'b0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp <= '0;
         rsp_timeout <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr <= '0;
         m_axi_wvalid <= 1'b0;
         m_axi_wdata <= '0;
         m_axi_bready <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr <= '0;
         m_axi_rready <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  m_axi_awaddr <= cmd_addr;
                  m_axi_araddr <= cmd_addr;
                  m_axi_wdata <= cmd_wdata;
                  m_axi_awvalid <= cmd_write;
                  m_axi_wvalid <= cmd_write;
                  m_axi_arvalid <= !cmd_write;
                  state <= cmd_write ? WR_ADDR_DATA : RD_ADDR;
               end
            end
            WR_ADDR_DATA: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready) m_axi_wvalid <= 1'b0;
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  cnt <= '0;
                  state <= WR_RESP;
               end
            end
            WR_RESP: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
               rsp_resp <= m_axi_bresp;
               rsp_timeout <= 1'b0;
               state <= RSP;
            end
            RD_ADDR: if (m_axi_arready) begin
               m_axi_arvalid <= 1'b0;
               m_axi_rready <= 1'b1;
               cnt <= '0;
               state <= RD_DATA;
            end
            RD_DATA: if (m_axi_rvalid) begin
               m_axi_rready <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= m_axi_rdata;
               rsp_resp <= m_axi_rresp;
               rsp_timeout <= 1'b0;
               state <= RSP;
            end
            RSP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (expired) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid <= 1'b0;
            m_axi_bready <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp <= 2'b10;
            rsp_timeout <= 1'b1;
            state <= RSP;
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: randomized slave and command traffic scored against a transaction-level response model
module tb_axi_lite_cmd_master;
   localparam int AW = 4;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0] rsp_resp;
   logic m_axi_awvalid, m_axi_awready = 1'b0, m_axi_wvalid, m_axi_wready = 1'b0;
   logic m_axi_bvalid = 1'b0, m_axi_bready, m_axi_arvalid, m_axi_arready = 1'b0;
   logic m_axi_rvalid = 1'b0, m_axi_rready;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0] m_axi_awprot, m_axi_arprot;
   logic [31:0] m_axi_wdata, m_axi_rdata = '0;
   logic [3:0] m_axi_wstrb;
   logic [1:0] m_axi_bresp = '0, m_axi_rresp = '0;
   always #5 clk = ~clk;
   axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
   );
   typedef struct {
      bit wr;
      logic [AW-1:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0] resp;
      bit to;
   } txn_t;
   txn_t exp_q[$];
   txn_t e;
   int total = 0, bad = 0;
   int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0, hold = 0;
   bit rsp_rand = 0;
   logic [1:0] b_code = '0, r_code = '0;
   logic [31:0] r_word = '0;
   int na = 0, nw = 0, nb = 0, nar = 0, nr = 0;
   int n_awhi = 0, n_whi = 0, n_arhi = 0, n_b = 0, n_rsphi = 0, n_acc = 0, n_iss = 0, lat = 0;
   logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
   logic [31:0] last_wdata = '0, last_rdata = '0;
   logic [3:0] last_wstrb = '0;
   logic [1:0] last_resp = '0;
   logic last_to = 1'b0;
   logic p_rst = 1'b1, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
   logic p_bv = 0, p_br = 0, p_rv = 0, p_rr = 0, p_sv = 0, p_sr = 0;
   logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
   logic [31:0] p_wdata = '0, p_rdata = '0;
   logic [2:0] p_rsp = '0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   // slave: each ready/valid pulses once its channel has been active for the chosen number of cycles
   initial forever begin
      @(negedge clk);
      #1;
      m_axi_awready = m_axi_awvalid && na == aw_d;
      na = m_axi_awvalid ? na + 1 : 0;
      m_axi_wready = m_axi_wvalid && nw == w_d;
      nw = m_axi_wvalid ? nw + 1 : 0;
      m_axi_arready = m_axi_arvalid && nar == ar_d;
      nar = m_axi_arvalid ? nar + 1 : 0;
      m_axi_bvalid = m_axi_bready && nb == b_d;
      m_axi_bresp = b_code;
      nb = m_axi_bready ? nb + 1 : 0;
      m_axi_rvalid = m_axi_rready && nr == r_d;
      m_axi_rdata = r_word;
      m_axi_rresp = r_code;
      nr = m_axi_rready ? nr + 1 : 0;
      if (hold > 0) begin
         rsp_ready = 1'b0;
         hold--;
      end else rsp_ready = rsp_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
   end
   initial forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
         if (cmd_ready) chk("idle_quiet", {rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
         if (cmd_valid && cmd_ready) begin
            n_acc++;
            n_awhi = 0; n_whi = 0; n_arhi = 0; n_b = 0; n_rsphi = 0;
         end
         if (m_axi_awvalid) n_awhi++;
         if (m_axi_wvalid) n_whi++;
         if (m_axi_arvalid) n_arhi++;
         if (rsp_valid) n_rsphi++;
         if (!p_rst) begin
            if (p_awv && p_awr) chk("aw_drop", m_axi_awvalid, 0);
            if (p_wv && p_wr) chk("w_drop", m_axi_wvalid, 0);
            if (p_arv && p_arr) chk("ar_drop", m_axi_arvalid, 0);
            if (p_bv && p_br) chk("b_drop", m_axi_bready, 0);
            if (p_rv && p_rr) chk("r_drop", m_axi_rready, 0);
            if (p_awv && m_axi_awvalid) chk("aw_stable", m_axi_awaddr, p_awaddr);
            if (p_wv && m_axi_wvalid) chk("w_stable", m_axi_wdata, p_wdata);
            if (p_arv && m_axi_arvalid) chk("ar_stable", m_axi_araddr, p_araddr);
            if (p_sv && !p_sr) begin
               chk("rsp_hold_valid", rsp_valid, 1);
               chk("rsp_hold_data", rsp_rdata, p_rdata);
               chk("rsp_hold_code", {rsp_timeout, rsp_resp}, p_rsp);
            end
         end
         if (m_axi_awvalid && m_axi_awready) begin
            last_awaddr = m_axi_awaddr;
            chk("aw_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               chk("aw_dir", exp_q[0].wr, 1);
               chk("aw_addr", m_axi_awaddr, exp_q[0].addr);
               chk("aw_prot", m_axi_awprot, 0);
            end
         end
         if (m_axi_wvalid && m_axi_wready) begin
            last_wdata = m_axi_wdata;
            last_wstrb = m_axi_wstrb;
            chk("w_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               chk("w_dir", exp_q[0].wr, 1);
               chk("w_data", m_axi_wdata, exp_q[0].wdata);
               chk("w_strb", m_axi_wstrb, 4'hf);
            end
         end
         if (m_axi_arvalid && m_axi_arready) begin
            last_araddr = m_axi_araddr;
            chk("ar_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               chk("ar_dir", exp_q[0].wr, 0);
               chk("ar_addr", m_axi_araddr, exp_q[0].addr);
               chk("ar_prot", m_axi_arprot, 0);
            end
         end
         if (m_axi_bvalid && m_axi_bready) n_b++;
         if (rsp_valid && rsp_ready) begin
            last_rdata = rsp_rdata;
            last_resp = rsp_resp;
            last_to = rsp_timeout;
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_resp", rsp_resp, e.resp);
               chk("rsp_timeout", rsp_timeout, e.to);
            end
         end
      end
      p_rst = rst;
      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_wv = m_axi_wvalid; p_wr = m_axi_wready;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_bv = m_axi_bvalid; p_br = m_axi_bready;
      p_rv = m_axi_rvalid; p_rr = m_axi_rready; p_sv = rsp_valid; p_sr = rsp_ready;
      p_awaddr = m_axi_awaddr; p_araddr = m_axi_araddr; p_wdata = m_axi_wdata;
      p_rdata = rsp_rdata; p_rsp = {rsp_timeout, rsp_resp};
   end
   // expected outcome: any phase whose slave delay reaches the timeout budget turns into a SLVERR timeout
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input int daw, input int dw, input int db, input int dar, input int dr,
                        input logic [1:0] bc, input logic [1:0] rc, input logic [31:0] rw, input bit junk);
      txn_t t;
      int k;
      int guard = 0;
      while (!cmd_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      aw_d = daw; w_d = dw; b_d = db; ar_d = dar; r_d = dr;
      b_code = bc; r_code = rc; r_word = rw;
      t.wr = wr;
      t.addr = a;
      t.wdata = wd;
      t.to = wr ? (daw >= TO || dw >= TO || db >= TO) : (dar >= TO || dr >= TO);
      t.resp = t.to ? 2'b10 : (wr ? bc : rc);
      t.rdata = (t.to || wr) ? 32'h0 : rw;
      exp_q.push_back(t);
      n_iss++;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      lat = -1;
      for (k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (lat < 0 && rsp_valid) lat = k;
         if (cmd_ready) break;
         cmd_valid = junk && ($urandom_range(1, 0) == 1);
         cmd_write = 1'($urandom_range(1, 0));
         cmd_addr = AW'($urandom);
         cmd_wdata = $urandom;
      end
      cmd_valid = 1'b0;
      if (k > 300) begin
         total++;
         bad++;
         $display("FAIL txn_done: cmd_ready got 0 want 1 within 300 cycles");
      end
   endtask
   function automatic int rdly();
      int r = $urandom_range(99, 0);
      if (r < 80) return $urandom_range(3, 0);
      if (r < 87) return TO - 1;
      if (r < 94) return TO;
      return 40;
   endfunction
   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_axi_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
      chk("rst_rsp_data", rsp_rdata, 0);
      chk("rst_rsp_code", {rsp_timeout, rsp_resp}, 0);
      chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 0);
      chk("rst_wdata", m_axi_wdata, 0);
      chk("rst_wstrb", m_axi_wstrb, 4'hf);
      rst = 1'b0;
      issue(1, 4'h4, 32'h000000A5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0);
      chk("wr_latency", lat, 3);
      chk("wr_awaddr", last_awaddr, 4'h4);
      chk("wr_wdata", last_wdata, 32'hA5);
      chk("wr_wstrb", last_wstrb, 4'hf);
      chk("wr_rsp", {last_to, last_resp}, 3'b000);
      issue(0, 4'h2, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFEF00D, 0);
      chk("rd_latency", lat, 3);
      chk("rd0_rdata", last_rdata, 32'hCAFEF00D);
      issue(0, 4'h8, 32'h0, 0, 0, 0, 0, 5, 2'b00, 2'b00, 32'h12345678, 0);
      chk("rd_araddr", last_araddr, 4'h8);
      chk("rd_rdata", last_rdata, 32'h12345678);
      chk("rd_rsp", {last_to, last_resp}, 3'b000);
      issue(1, 4'hC, 32'hDEADBEEF, 3, 0, 2, 0, 0, 2'b01, 2'b00, 32'h0, 0);
      chk("skew_aw_cycles", n_awhi, 4);
      chk("skew_w_cycles", n_whi, 1);
      chk("skew_b_count", n_b, 1);
      chk("skew_rsp", {last_to, last_resp}, 3'b001);
      issue(0, 4'h6, 32'h0, 0, 0, 0, 1000, 0, 2'b00, 2'b00, 32'h99, 0);
      chk("to_ar_cycles", n_arhi, 16);
      chk("to_rsp", {last_to, last_resp}, 3'b110);
      chk("to_rdata", last_rdata, 0);
      issue(0, 4'h6, 32'h0, 0, 0, 0, TO - 1, 0, 2'b00, 2'b11, 32'h55, 0);
      chk("edge_rsp", {last_to, last_resp}, 3'b011);
      chk("edge_rdata", last_rdata, 32'h55);
      issue(1, 4'h1, 32'h1, 0, 0, TO, 0, 0, 2'b00, 2'b00, 32'h0, 0);
      chk("bto_rsp", {last_to, last_resp}, 3'b110);
      hold = 13;
      issue(0, 4'h3, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h77, 1);
      chk("bp_rsp_cycles", n_rsphi, 11);
      chk("bp_rdata", last_rdata, 32'h77);
      aw_d = 0; w_d = 0; b_d = 50;
      e.wr = 1; e.addr = 4'h5; e.wdata = 32'h5; e.rdata = 0; e.resp = 0; e.to = 0;
      exp_q.push_back(e);
      n_iss++;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 32'h5;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && !m_axi_bready; i++) @(negedge clk);
      chk("rstw_bready_before", m_axi_bready, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_bready", m_axi_bready, 0);
      chk("rstw_rsp_valid", rsp_valid, 0);
      chk("rstw_cmd_ready", cmd_ready, 1);
      exp_q.delete();
      rst = 1'b0;
      rsp_rand = 1;
      repeat (250) issue(1'($urandom_range(1, 0)), AW'($urandom), $urandom, rdly(), rdly(), rdly(), rdly(), rdly(),
                         2'($urandom), 2'($urandom), $urandom, 1);
      chk("accept_count", n_acc, n_iss);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
